// File: rtl/io_host_bridge.sv
// Host byte-stream to I/O bus master: decodes framed read/write commands,
// issues single-cycle bus strobes and returns read data or a write ack.
module io_host_bridge #(
    parameter int         ADDR_W = 16,
    parameter logic [7:0] CMD_WR = 8'h57,
    parameter logic [7:0] CMD_RD = 8'h52,
    parameter logic [7:0] ACK    = 8'h4B
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              io_rd,
    output logic              io_wr,
    output logic [ADDR_W-1:0] io_addr,
    output logic [15:0]       io_dout,
    input  logic [15:0]       io_din,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    typedef enum logic [3:0] {
        IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L,
        EXEC, RESP_H, RESP_L, ACKS
    } state_t;

    state_t      state_q, state_n;
    logic        op_wr_q, op_wr_n;
    logic [15:0] addr_q, addr_n;
    logic [15:0] data_q, data_n;
    logic [7:0]  rd_lo_q;
    logic [7:0]  err_n;
    logic        rx_fire, tx_fire;

    assign rx_fire = rx_valid & rx_ready;
    assign tx_fire = tx_valid & tx_ready;

    always_comb begin
        state_n = state_q;
        op_wr_n = op_wr_q;
        addr_n  = addr_q;
        data_n  = data_q;
        err_n   = err_cnt;
        unique case (state_q)
            IDLE: if (rx_fire) begin
                if (rx_data == CMD_WR) begin
                    state_n = ADDR_H;
                    op_wr_n = 1'b1;
                end else if (rx_data == CMD_RD) begin
                    state_n = ADDR_H;
                    op_wr_n = 1'b0;
                end else if (err_cnt != 8'hFF) begin
                    err_n = err_cnt + 8'd1;
                end
            end
            ADDR_H: if (rx_fire) begin
                addr_n[15:8] = rx_data;
                state_n      = ADDR_L;
            end
            ADDR_L: if (rx_fire) begin
                addr_n[7:0] = rx_data;
                state_n     = op_wr_q ? DATA_H : EXEC;
            end
            DATA_H: if (rx_fire) begin
                data_n[15:8] = rx_data;
                state_n      = DATA_L;
            end
            DATA_L: if (rx_fire) begin
                data_n[7:0] = rx_data;
                state_n     = EXEC;
            end
            EXEC:   state_n = op_wr_q ? ACKS : RESP_H;
            RESP_H: if (tx_fire) state_n = RESP_L;
            RESP_L: if (tx_fire) state_n = IDLE;
            ACKS:   if (tx_fire) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_wr_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            rd_lo_q  <= '0;
            err_cnt  <= '0;
            rx_ready <= 1'b1;
            busy     <= 1'b0;
            io_rd    <= 1'b0;
            io_wr    <= 1'b0;
            io_addr  <= '0;
            io_dout  <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            state_q  <= state_n;
            op_wr_q  <= op_wr_n;
            addr_q   <= addr_n;
            data_q   <= data_n;
            err_cnt  <= err_n;
            rx_ready <= state_n inside {IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L};
            busy     <= state_n != IDLE;
            io_wr    <= (state_n == EXEC) && op_wr_n;
            io_rd    <= (state_n == EXEC) && !op_wr_n;
            tx_valid <= state_n inside {RESP_H, RESP_L, ACKS};
            if (state_n == EXEC) begin
                io_addr <= addr_n[ADDR_W-1:0];
                if (op_wr_n) io_dout <= data_n;
            end
            if (state_q == EXEC) begin
                rd_lo_q <= io_din[7:0];
                tx_data <= op_wr_q ? ACK : io_din[15:8];
            end else if (state_q == RESP_H && tx_fire) begin
                tx_data <= rd_lo_q;
            end
        end
    end

endmodule

// File: tb/tb_io_host_bridge.sv
// Directed self-checking bench for io_host_bridge: writes, reads,
// backpressure, bad bytes, mid-frame reset and back-to-back frames.
module tb_io_host_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;
    logic        busy;
    logic [7:0]  err_cnt;

    logic [15:0] rd_val;
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          both_hi = 0;
    int          unstable = 0;
    logic [15:0] wr_addr, wr_data, rd_addr;
    logic [7:0]  txq[$];
    logic        hold_q = 1'b0;
    logic [7:0]  hold_d = 8'h00;

    io_host_bridge dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
        .io_dout(io_dout), .io_din(io_din),
        .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    assign io_din = io_rd ? rd_val : 16'h0000;

    // Bus/tx monitor sampled mid-cycle; a tx byte is logged the cycle before it transfers
    always @(negedge clk) begin
        if (io_wr) begin
            wr_cnt++;
            wr_addr = io_addr;
            wr_data = io_dout;
        end
        if (io_rd) begin
            rd_cnt++;
            rd_addr = io_addr;
        end
        if (io_wr && io_rd) both_hi++;
        if (hold_q && tx_valid && tx_data !== hold_d) unstable++;
        if (!reset && tx_valid && tx_ready) txq.push_back(tx_data);
        hold_q = tx_valid && !tx_ready;
        hold_d = tx_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Leaves rx_valid high; returns at the negedge just after the transfer
    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("rx_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_tx(input int total);
        int n = 0;
        while (txq.size() < total && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tx_count", txq.size(), total);
        @(negedge clk);
    endtask

    initial begin
        rx_data = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        rd_val = 16'h0000;
        do_reset();

        check("rst_io_rd", io_rd, 0);
        check("rst_io_wr", io_wr, 0);
        check("rst_io_addr", io_addr, 0);
        check("rst_io_dout", io_dout, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_ready", rx_ready, 1);

        // Write 0x1234 to 0x0010
        send(8'h57); send(8'h00); send(8'h10); send(8'h12); send(8'h34);
        rx_valid = 1'b0;
        check("wr_strobe", io_wr, 1);
        check("wr_addr", io_addr, 16'h0010);
        check("wr_dout", io_dout, 16'h1234);
        check("wr_rx_ready", rx_ready, 0);
        check("wr_tx_early", tx_valid, 0);
        @(negedge clk);
        check("wr_strobe_off", io_wr, 0);
        check("wr_ack_valid", tx_valid, 1);
        check("wr_ack_data", tx_data, 8'h4B);
        wait_tx(1);
        check("wr_busy_after", busy, 0);
        check("wr_count", wr_cnt, 1);
        check("wr_txq0", txq[0], 8'h4B);

        // Read 0x0020
        rd_val = 16'h0A5C;
        send(8'h52); send(8'h00); send(8'h20);
        rx_valid = 1'b0;
        check("rd_strobe", io_rd, 1);
        check("rd_addr", io_addr, 16'h0020);
        check("rd_dout_kept", io_dout, 16'h1234);
        wait_tx(3);
        check("rd_txq_hi", txq[1], 8'h0A);
        check("rd_txq_lo", txq[2], 8'h5C);
        check("rd_count", rd_cnt, 1);

        // Backpressure; din changes after capture and a held rx byte is ignored
        tx_ready = 1'b0;
        send(8'h52); send(8'h00); send(8'h20);
        rx_data = 8'h57;
        @(negedge clk);
        rd_val = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            check("bp_tx_valid", tx_valid, 1);
            check("bp_tx_data", tx_data, 8'h0A);
            check("bp_rx_ready", rx_ready, 0);
            @(negedge clk);
        end
        check("bp_rd_count", rd_cnt, 2);
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        wait_tx(5);
        check("bp_txq_hi", txq[3], 8'h0A);
        check("bp_txq_lo", txq[4], 8'h5C);
        check("bp_idle", busy, 0);
        check("bp_no_write", wr_cnt, 1);

        // Bad bytes then a write
        send(8'h00); send(8'hFF);
        send(8'h57); send(8'h00); send(8'h01); send(8'h00); send(8'h02);
        rx_valid = 1'b0;
        wait_tx(6);
        check("bad_err_cnt", err_cnt, 2);
        check("bad_wr_count", wr_cnt, 2);
        check("bad_wr_addr", wr_addr, 16'h0001);
        check("bad_wr_data", wr_data, 16'h0002);
        check("bad_ack", txq[5], 8'h4B);
        for (int i = 0; i < 298; i++) send(8'h11);
        rx_valid = 1'b0;
        @(negedge clk);
        check("err_saturate", err_cnt, 8'hFF);
        check("err_no_bus", wr_cnt + rd_cnt, 4);

        // Reset mid-frame
        send(8'h57); send(8'h00);
        rx_valid = 1'b0;
        check("mid_busy", busy, 1);
        do_reset();
        check("mrst_busy", busy, 0);
        check("mrst_rx_ready", rx_ready, 1);
        check("mrst_err", err_cnt, 0);
        check("mrst_tx_valid", tx_valid, 0);
        check("mrst_no_wr", wr_cnt, 2);
        rd_val = 16'h1234;
        send(8'h52); send(8'h00); send(8'h30);
        rx_valid = 1'b0;
        check("mrst_rd_strobe", io_rd, 1);
        check("mrst_rd_addr", io_addr, 16'h0030);
        wait_tx(8);
        check("mrst_hi", txq[6], 8'h12);
        check("mrst_lo", txq[7], 8'h34);
        check("mrst_wr_count", wr_cnt, 2);

        // Back-to-back write then read with rx_valid held high
        rd_val = 16'hBEEF;
        send(8'h57); send(8'h00); send(8'h40); send(8'hAB); send(8'hCD);
        send(8'h52); send(8'h00); send(8'h41);
        rx_valid = 1'b0;
        wait_tx(11);
        check("b2b_wr_count", wr_cnt, 3);
        check("b2b_rd_count", rd_cnt, 4);
        check("b2b_wr_addr", wr_addr, 16'h0040);
        check("b2b_wr_data", wr_data, 16'hABCD);
        check("b2b_rd_addr", rd_addr, 16'h0041);
        check("b2b_ack", txq[8], 8'h4B);
        check("b2b_hi", txq[9], 8'hBE);
        check("b2b_lo", txq[10], 8'hEF);
        check("b2b_idle", busy, 0);
        check("never_both", both_hi, 0);
        check("tx_stable", unstable, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
